tape_unit_project_id: RTL and testbench
=======================================

// Module: tape_unit_PROJECT_ID
// PURPOSE
// - Tape storage, head pointer and machine-state register of the universal Turing machine.
// - Drives the current one-hot state and head symbol into the transition stage
//   (direction/next-state/write-symbol blocks).
// - Consumes their outputs to commit one machine step: write the cell, move the head, update the state.
// - Also handles serial tape load before a run and serial tape dump after a run.
// PARAMETERS
// - TAPE_LEN    16      number of tape cells, each 3 bits; 2..64
// - HEAD_INIT   8       head cell index after reset/start; < TAPE_LEN
// - HALT_STATE  8'h80   one-hot state that ends a run (state H)
// - START_STATE 8'h01   one-hot state loaded on start (state A)
// PORTS
// - clk         in   1  clock, rising edge
// - rst_n       in   1  asynchronous active-low reset
// - load_en     in   1  IDLE only: write load_sym to cell load_ptr, then load_ptr+1
// - load_sym    in   3  symbol to load
// - start       in   1  1-cycle pulse: begin run from IDLE or HALT
// - dump_en     in   1  IDLE/HALT only: present cell dump_ptr on dump_sym, then dump_ptr+1
// - direction   in   1  from direction stage; 1 = right (head+1), 0 = left (head-1)
// - write_sym   in   3  symbol to write at head
// - next_state  in   8  one-hot next state
// - state       out  8  current one-hot state, registered
// - s2, s1, s0  out  1  registered head symbol bits to transition stage
// - dump_sym    out  3  registered dump data
// - busy        out  1  high in READ/EXEC
// - halted      out  1  high in HALT
// - fault       out  1  high in FAULT
// - steps       out 16  completed-step counter, saturating at 16'hFFFF
// BEHAVIOUR
// - Reset: all cells 3'b000, head=HEAD_INIT, state=8'h00, {s2,s1,s0}=0, dump_sym=0,
//   steps=0, load_ptr=0, dump_ptr=0, FSM=IDLE, flags low.
// - FSM states: IDLE, READ, EXEC, HALT, FAULT.
// - IDLE
//   - load_en: cell[load_ptr] <= load_sym; load_ptr wraps TAPE_LEN-1 -> 0.
//   - dump_en: dump_sym <= cell[dump_ptr]; dump_ptr increments and wraps.
//   - load_en and dump_en in the same cycle: load wins; dump is ignored.
//   - start: head <= HEAD_INIT, state <= START_STATE, steps <= 0, dump_ptr <= 0, -> READ.
//     Same-cycle load_en is ignored.
// - READ (1 cycle): {s2,s1,s0} <= cell[head]; -> EXEC.
//   - If state == HALT_STATE, the transition is -> HALT instead.
// - EXEC (1 cycle): samples direction, write_sym, next_state.
//   - Transition inputs must be stable by then: comb from state/s* held since READ.
//   - cell[head] <= write_sym; state <= next_state; steps++ (saturating).
//   - Head move: head+1 if direction=1, head-1 if direction=0.
//   - Off the tape (head==TAPE_LEN-1 moving right, or head==0 moving left): write and state
//     update still happen; head is unchanged; -> FAULT.
//   - next_state not one-hot (zero or more than one bit set): no write, no move,
//     state unchanged; -> FAULT.
//   - Otherwise -> READ.
// - Throughput: 2 cycles per step. Latency from start to first EXEC: 2 cycles.
// - HALT: flags only. start re-runs over the current tape contents (no reload).
//   dump_en is allowed; load_en is ignored.
// - FAULT: frozen. Only rst_n exits. dump_en is ignored.
// - start in READ/EXEC is ignored. load_en and dump_en outside their allowed states are ignored.
// - rst_n asserted mid-run: immediate return to reset values; tape contents are cleared.
// - busy/halted/fault decode the FSM state from registers: exactly one is high or none (IDLE).
// TESTING
// - Load 16 symbols 0..7,0..7 via load_en, then dump -> dump_sym returns the same sequence;
//   load_ptr wraps after 16.
// - Tape all 0; stub sets next_state=HALT_STATE, write_sym=3'b001, direction=1; start ->
//   halted after 3 cycles, steps=1, cell[8]=1, head=9.
// - Three-state busy-beaver stub (A->B->C->H) with real direction stage -> halted,
//   steps and tape match golden model.
// - head=HEAD_INIT=0 (parameter override), direction=0 -> fault=1, cell[0] written,
//   head stays 0, later start ignored.
// - next_state=8'h03 in EXEC -> fault=1, state unchanged, cell unchanged.
// - Assert rst_n during EXEC -> next edge shows state=0, busy=0, steps=0; dump returns all zeros.

Source files
------------

// File: rtl/tape_unit_project_id.sv
// Tape storage, head pointer and one-hot machine state of the universal
// Turing machine. One machine step takes two cycles: READ latches the head
// symbol for the external transition stage, EXEC commits that stage's answer.
// Control inputs (i_load_en, i_dump_en, i_start) are single-cycle strobes
// sampled on the rising edge; each has an effect only in the FSM states that
// accept it and is silently dropped elsewhere.
// A step that runs off the tape still writes the cell and updates the state
// (and so counts as a completed step) before the unit freezes in FAULT.
module tape_unit_project_id #(
    parameter int          TAPE_LEN    = 16,
    parameter int          HEAD_INIT   = 8,
    parameter logic [7:0]  HALT_STATE  = 8'h80,
    parameter logic [7:0]  START_STATE = 8'h01
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_load_en,
    input  logic [2:0]                  i_load_sym,
    input  logic                        i_start,
    input  logic                        i_dump_en,
    input  logic                        i_direction,
    input  logic [2:0]                  i_write_sym,
    input  logic [7:0]                  i_next_state,
    output logic [7:0]                  o_state,
    output logic                        o_s2,
    output logic                        o_s1,
    output logic                        o_s0,
    output logic [2:0]                  o_dump_sym,
    output logic                        o_busy,
    output logic                        o_halted,
    output logic                        o_fault,
    output logic [15:0]                 o_steps,
    output logic [2:0]                  o_dbg_fsm,
    output logic [$clog2(TAPE_LEN)-1:0] o_dbg_head,
    output logic [2:0]                  o_dbg_cell
);
    localparam int             PW       = $clog2(TAPE_LEN);
    localparam logic [PW-1:0]  LAST_IDX = PW'(TAPE_LEN - 1);
    localparam logic [PW-1:0]  HEAD0    = PW'(HEAD_INIT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fsm_t;

    fsm_t          r_fsm;
    logic [2:0]    r_tape [TAPE_LEN];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_load_ptr;
    logic [PW-1:0] r_dump_ptr;
    logic [7:0]    r_state;
    logic [2:0]    r_sym;
    logic [2:0]    r_dump_sym;
    logic [15:0]   r_steps;

    logic w_onehot;
    logic w_off_tape;

    // Step legality: next state must have exactly one bit set, and the move must stay on the tape.
    assign w_onehot   = (i_next_state != 8'h00) && ((i_next_state & (i_next_state - 8'd1)) == 8'h00);
    assign w_off_tape = i_direction ? (r_head == LAST_IDX) : (r_head == '0);

    // Whole machine: tape, pointers, state register and control FSM in one registered block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TAPE_LEN; i++) r_tape[i] <= 3'b000;
            r_head     <= HEAD0;
            r_load_ptr <= '0;
            r_dump_ptr <= '0;
            r_state    <= 8'h00;
            r_sym      <= 3'b000;
            r_dump_sym <= 3'b000;
            r_steps    <= 16'h0000;
            r_fsm      <= ST_IDLE;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (i_start) begin
                        r_head     <= HEAD0;
                        r_state    <= START_STATE;
                        r_steps    <= 16'h0000;
                        r_dump_ptr <= '0;
                        r_fsm      <= ST_READ;
                    end else if (i_load_en) begin
                        r_tape[r_load_ptr] <= i_load_sym;
                        r_load_ptr <= (r_load_ptr == LAST_IDX) ? '0 : r_load_ptr + 1'b1;
                    end else if (i_dump_en) begin
                        r_dump_sym <= r_tape[r_dump_ptr];
                        r_dump_ptr <= (r_dump_ptr == LAST_IDX) ? '0 : r_dump_ptr + 1'b1;
                    end
                end
                ST_READ: begin
                    r_sym <= r_tape[r_head];
                    r_fsm <= (r_state == HALT_STATE) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    if (!w_onehot) begin
                        r_fsm <= ST_FAULT;
                    end else begin
                        r_tape[r_head] <= i_write_sym;
                        r_state        <= i_next_state;
                        if (r_steps != 16'hFFFF) r_steps <= r_steps + 16'd1;
                        if (w_off_tape) begin
                            r_fsm <= ST_FAULT;
                        end else begin
                            r_head <= i_direction ? r_head + 1'b1 : r_head - 1'b1;
                            r_fsm  <= ST_READ;
                        end
                    end
                end
                ST_HALT: begin
                    if (i_start) begin
                        r_head     <= HEAD0;
                        r_state    <= START_STATE;
                        r_steps    <= 16'h0000;
                        r_dump_ptr <= '0;
                        r_fsm      <= ST_READ;
                    end else if (i_dump_en) begin
                        r_dump_sym <= r_tape[r_dump_ptr];
                        r_dump_ptr <= (r_dump_ptr == LAST_IDX) ? '0 : r_dump_ptr + 1'b1;
                    end
                end
                ST_FAULT: begin
                    r_fsm <= ST_FAULT;
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_state    = r_state;
    assign o_s2       = r_sym[2];
    assign o_s1       = r_sym[1];
    assign o_s0       = r_sym[0];
    assign o_dump_sym = r_dump_sym;
    assign o_steps    = r_steps;
    assign o_busy     = (r_fsm == ST_READ) || (r_fsm == ST_EXEC);
    assign o_halted   = (r_fsm == ST_HALT);
    assign o_fault    = (r_fsm == ST_FAULT);
    assign o_dbg_fsm  = r_fsm;
    assign o_dbg_head = r_head;
    assign o_dbg_cell = r_tape[r_head];
endmodule

// File: tb/tb_tape_unit_project_id.sv
// Bench for tape_unit_project_id: a table-driven transition stage feeds the
// DUT, and a step-by-step reference machine predicts the final tape, head,
// state, step count and halt/fault outcome.
module tb_tape_unit_project_id;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load_en, start, dump_en;
  logic [2:0]  load_sym;
  logic        t_dir;
  logic [2:0]  t_ws;
  logic [7:0]  t_ns;
  logic [7:0]  o_state;
  logic        o_s2, o_s1, o_s0, o_busy, o_halted, o_fault;
  logic [2:0]  o_dump_sym, o_dbg_fsm, o_dbg_cell;
  logic [15:0] o_steps;
  logic [3:0]  o_dbg_head;

  // second instance with the head starting at cell 0
  logic        z_start;
  logic        z_dir;
  logic [2:0]  z_ws;
  logic [7:0]  z_ns;
  logic [7:0]  z_state;
  logic        z_s2, z_s1, z_s0, z_busy, z_halted, z_fault;
  logic [2:0]  z_dump_sym, z_dbg_fsm, z_dbg_cell;
  logic [15:0] z_steps;
  logic [3:0]  z_dbg_head;

  int n_cmp = 0;
  int n_bad = 0;

  // transition stage: fixed stub or per-(state,symbol) table
  logic        use_tbl;
  logic        stub_dir;
  logic [2:0]  stub_ws;
  logic [7:0]  stub_ns;
  logic        tbl_dir [0:2][0:7];
  logic [2:0]  tbl_ws  [0:2][0:7];
  logic [7:0]  tbl_ns  [0:2][0:7];
  logic [2:0]  cur_sym;

  // reference machine
  logic [2:0]  m_tape [16];
  logic [2:0]  init_tape [16];
  int          m_head;
  logic [7:0]  m_state;
  int          m_steps;
  logic [2:0]  exp_q[$];

  assign cur_sym = {o_s2, o_s1, o_s0};

  always_comb begin
    t_dir = stub_dir;
    t_ws  = stub_ws;
    t_ns  = stub_ns;
    if (use_tbl) begin
      t_dir = 1'b1;
      t_ws  = 3'd0;
      t_ns  = 8'h80;
      case (o_state)
        8'h01: begin t_dir = tbl_dir[0][cur_sym]; t_ws = tbl_ws[0][cur_sym]; t_ns = tbl_ns[0][cur_sym]; end
        8'h02: begin t_dir = tbl_dir[1][cur_sym]; t_ws = tbl_ws[1][cur_sym]; t_ns = tbl_ns[1][cur_sym]; end
        8'h04: begin t_dir = tbl_dir[2][cur_sym]; t_ws = tbl_ws[2][cur_sym]; t_ns = tbl_ns[2][cur_sym]; end
        default: ;
      endcase
    end
  end

  tape_unit_project_id dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_en(load_en), .i_load_sym(load_sym),
    .i_start(start), .i_dump_en(dump_en), .i_direction(t_dir), .i_write_sym(t_ws),
    .i_next_state(t_ns), .o_state(o_state), .o_s2(o_s2), .o_s1(o_s1), .o_s0(o_s0),
    .o_dump_sym(o_dump_sym), .o_busy(o_busy), .o_halted(o_halted), .o_fault(o_fault),
    .o_steps(o_steps), .o_dbg_fsm(o_dbg_fsm), .o_dbg_head(o_dbg_head), .o_dbg_cell(o_dbg_cell)
  );

  tape_unit_project_id #(.HEAD_INIT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_en(1'b0), .i_load_sym(3'd0),
    .i_start(z_start), .i_dump_en(1'b0), .i_direction(z_dir), .i_write_sym(z_ws),
    .i_next_state(z_ns), .o_state(z_state), .o_s2(z_s2), .o_s1(z_s1), .o_s0(z_s0),
    .o_dump_sym(z_dump_sym), .o_busy(z_busy), .o_halted(z_halted), .o_fault(z_fault),
    .o_steps(z_steps), .o_dbg_fsm(z_dbg_fsm), .o_dbg_head(z_dbg_head), .o_dbg_cell(z_dbg_cell)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load_en = 1'b0; dump_en = 1'b0; start = 1'b0; z_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic load_one(input logic [2:0] s);
    load_sym = s; load_en = 1'b1; tick(); load_en = 1'b0;
  endtask

  task automatic dump_one(output logic [2:0] s);
    dump_en = 1'b1; tick(); dump_en = 1'b0; s = o_dump_sym;
  endtask

  task automatic wait_done(input int budget);
    n_cmp++;
    for (int c = 0; c < budget; c++) begin
      if (o_halted || o_fault) return;
      tick();
    end
    if (!(o_halted || o_fault)) begin
      n_bad++;
      $display("FAIL wait_done: no halt/fault after %0d cycles, required halt or fault", budget);
    end
  endtask

  function automatic int st_idx(input logic [7:0] s);
    if (s == 8'h01) return 0;
    if (s == 8'h02) return 1;
    return 2;
  endfunction

  // Runs the machine rules directly on the array tape; res 0=halt, 1=fault, 2=still running.
  task automatic model_run(input int max_steps, output int res);
    int si, nh;
    logic [2:0] sy;
    logic [7:0] ns;
    m_head = 8; m_state = 8'h01; m_steps = 0; res = 2;
    for (int k = 0; k <= max_steps; k++) begin
      if (m_state == 8'h80) begin res = 0; return; end
      si = st_idx(m_state);
      sy = m_tape[m_head];
      ns = tbl_ns[si][sy];
      if ($countones(ns) != 1) begin res = 1; return; end
      m_tape[m_head] = tbl_ws[si][sy];
      m_state = ns;
      m_steps++;
      nh = tbl_dir[si][sy] ? m_head + 1 : m_head - 1;
      if (nh < 0 || nh > 15) begin res = 1; return; end
      m_head = nh;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (o_state !== 8'h00 || cur_sym !== 3'd0 || o_dump_sym !== 3'd0) begin
      n_bad++; $display("FAIL reset_regs: state=%h sym=%0d dump=%0d, required 00/0/0", o_state, cur_sym, o_dump_sym);
    end
    n_cmp++;
    if (o_steps !== 16'd0 || {o_busy, o_halted, o_fault} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: steps=%0d flags=%b, required 0/000", o_steps, {o_busy, o_halted, o_fault});
    end
    n_cmp++;
    if (o_dbg_head !== 4'd8 || z_dbg_head !== 4'd0) begin
      n_bad++; $display("FAIL reset_head: head=%0d head0=%0d, required 8/0", o_dbg_head, z_dbg_head);
    end
  endtask

  task automatic test_load_dump();
    logic [2:0] exp_t [16];
    logic [2:0] got, e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_t[i] = 3'(i % 8);
      load_one(3'(i % 8));
    end
    load_one(3'd5);  // pointer wrapped: lands in cell 0
    exp_t[0] = 3'd5;
    load_sym = 3'd6; load_en = 1'b1; dump_en = 1'b1; tick(); load_en = 1'b0; dump_en = 1'b0;
    exp_t[1] = 3'd6;
    n_cmp++;
    if (o_dump_sym !== 3'd0) begin
      n_bad++; $display("FAIL load_dump_same_cycle: dump_sym=%0d, required 0", o_dump_sym);
    end
    for (int i = 0; i < 17; i++) exp_q.push_back(exp_t[i % 16]);
    for (int i = 0; i < 17; i++) begin
      dump_one(got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL dump_cell%0d: got %0d, required %0d", i, got, e);
      end
    end
  endtask

  task automatic test_single_step();
    logic [2:0] got;
    do_reset();
    use_tbl = 1'b0; stub_ns = 8'h80; stub_ws = 3'd1; stub_dir = 1'b1;
    pulse_start();
    n_cmp++;
    if (o_busy !== 1'b1 || o_state !== 8'h01) begin
      n_bad++; $display("FAIL single_start: busy=%b state=%h, required 1/01", o_busy, o_state);
    end
    tick(); tick();
    n_cmp++;
    if (o_halted !== 1'b0) begin
      n_bad++; $display("FAIL single_early_halt: halted=%b, required 0", o_halted);
    end
    tick();
    n_cmp++;
    if (o_halted !== 1'b1 || o_steps !== 16'd1 || o_dbg_head !== 4'd9 || o_state !== 8'h80) begin
      n_bad++; $display("FAIL single_halt: halted=%b steps=%0d head=%0d state=%h, required 1/1/9/80",
                        o_halted, o_steps, o_dbg_head, o_state);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back((i == 8) ? 3'd1 : 3'd0);
    for (int i = 0; i < 16; i++) begin
      dump_one(got);
      n_cmp++;
      if (got !== exp_q[0]) begin
        n_bad++; $display("FAIL single_tape%0d: got %0d, required %0d", i, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got;
    load_one(3'd7);  // ignored in HALT
    stub_ws = 3'd2;
    pulse_start();
    tick(); tick(); tick();
    n_cmp++;
    if (o_halted !== 1'b1 || o_steps !== 16'd1 || o_dbg_head !== 4'd9) begin
      n_bad++; $display("FAIL rerun_halt: halted=%b steps=%0d head=%0d, required 1/1/9", o_halted, o_steps, o_dbg_head);
    end
    dump_one(got);
    n_cmp++;
    if (got !== 3'd0) begin
      n_bad++; $display("FAIL rerun_load_ignored: cell0=%0d, required 0", got);
    end
    for (int i = 1; i < 9; i++) dump_one(got);
    n_cmp++;
    if (got !== 3'd2) begin
      n_bad++; $display("FAIL rerun_cell8: got %0d, required 2", got);
    end
  endtask

  task automatic test_random();
    int res, r;
    logic [2:0] got;
    for (int trial = 0; trial < 7; trial++) begin
      do_reset();
      for (int i = 0; i < 16; i++) init_tape[i] = (trial == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      res = 2;
      for (int att = 0; att < 12 && res == 2; att++) begin
        for (int s = 0; s < 3; s++) begin
          for (int y = 0; y < 8; y++) begin
            tbl_ws[s][y]  = 3'($urandom_range(0, 7));
            tbl_dir[s][y] = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            tbl_ns[s][y] = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : (r < 11) ? 8'h04 : (r < 15) ? 8'h80 :
                           ($urandom_range(0, 1) ? 8'h03 : 8'h00);
          end
        end
        if (trial == 0) begin
          // three-state busy beaver: A0 1RB, A1 1RH, B0 0RC, B1 1RB, C0 1LC, C1 1LA
          tbl_ws[0][0] = 3'd1; tbl_dir[0][0] = 1'b1; tbl_ns[0][0] = 8'h02;
          tbl_ws[0][1] = 3'd1; tbl_dir[0][1] = 1'b1; tbl_ns[0][1] = 8'h80;
          tbl_ws[1][0] = 3'd0; tbl_dir[1][0] = 1'b1; tbl_ns[1][0] = 8'h04;
          tbl_ws[1][1] = 3'd1; tbl_dir[1][1] = 1'b1; tbl_ns[1][1] = 8'h02;
          tbl_ws[2][0] = 3'd1; tbl_dir[2][0] = 1'b0; tbl_ns[2][0] = 8'h04;
          tbl_ws[2][1] = 3'd1; tbl_dir[2][1] = 1'b0; tbl_ns[2][1] = 8'h01;
        end
        for (int i = 0; i < 16; i++) m_tape[i] = init_tape[i];
        model_run(100, res);
      end
      if (res == 2) continue;
      for (int i = 0; i < 16; i++) load_one(init_tape[i]);
      use_tbl = 1'b1;
      pulse_start();
      wait_done(400);
      n_cmp++;
      if ({o_halted, o_fault} !== ((res == 0) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL prog%0d_outcome: halted/fault=%b, required %b", trial, {o_halted, o_fault},
                          (res == 0) ? 2'b10 : 2'b01);
      end
      n_cmp++;
      if (o_steps !== 16'(m_steps) || o_state !== m_state || o_dbg_head !== 4'(m_head)) begin
        n_bad++; $display("FAIL prog%0d_regs: steps=%0d state=%h head=%0d, required %0d/%h/%0d",
                          trial, o_steps, o_state, o_dbg_head, m_steps, m_state, m_head);
      end
      if (res == 0) begin
        for (int i = 0; i < 16; i++) begin
          dump_one(got);
          n_cmp++;
          if (got !== m_tape[i]) begin
            n_bad++; $display("FAIL prog%0d_tape%0d: got %0d, required %0d", trial, i, got, m_tape[i]);
          end
        end
      end else begin
        n_cmp++;
        if (o_dbg_cell !== m_tape[m_head]) begin
          n_bad++; $display("FAIL prog%0d_fault_cell: got %0d, required %0d", trial, o_dbg_cell, m_tape[m_head]);
        end
      end
      use_tbl = 1'b0;
    end
  endtask

  task automatic test_bad_next_state();
    do_reset();
    for (int i = 0; i < 16; i++) load_one(3'((i + 1) % 8));
    use_tbl = 1'b0; stub_ns = 8'h03; stub_ws = 3'd7; stub_dir = 1'b1;
    pulse_start();
    wait_done(20);
    n_cmp++;
    if (o_fault !== 1'b1 || o_halted !== 1'b0 || o_state !== 8'h01 || o_steps !== 16'd0) begin
      n_bad++; $display("FAIL bad_ns: fault=%b halted=%b state=%h steps=%0d, required 1/0/01/0",
                        o_fault, o_halted, o_state, o_steps);
    end
    n_cmp++;
    if (o_dbg_head !== 4'd8 || o_dbg_cell !== 3'd1) begin
      n_bad++; $display("FAIL bad_ns_tape: head=%0d cell=%0d, required 8/1", o_dbg_head, o_dbg_cell);
    end
    pulse_start();
    dump_en = 1'b1; tick(); dump_en = 1'b0;
    tick(); tick();
    n_cmp++;
    if (o_fault !== 1'b1 || o_busy !== 1'b0 || o_state !== 8'h01 || o_dump_sym !== 3'd0) begin
      n_bad++; $display("FAIL bad_ns_frozen: fault=%b busy=%b state=%h dump=%0d, required 1/0/01/0",
                        o_fault, o_busy, o_state, o_dump_sym);
    end
  endtask

  task automatic test_left_edge();
    do_reset();
    z_dir = 1'b0; z_ws = 3'd5; z_ns = 8'h02;
    z_start = 1'b1; tick(); z_start = 1'b0;
    tick(); tick();
    n_cmp++;
    if (z_fault !== 1'b1 || z_state !== 8'h02 || z_steps !== 16'd1) begin
      n_bad++; $display("FAIL left_edge: fault=%b state=%h steps=%0d, required 1/02/1", z_fault, z_state, z_steps);
    end
    n_cmp++;
    if (z_dbg_head !== 4'd0 || z_dbg_cell !== 3'd5) begin
      n_bad++; $display("FAIL left_edge_tape: head=%0d cell0=%0d, required 0/5", z_dbg_head, z_dbg_cell);
    end
    z_start = 1'b1; tick(); z_start = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (z_fault !== 1'b1 || z_busy !== 1'b0 || z_steps !== 16'd1) begin
      n_bad++; $display("FAIL left_edge_start_ignored: fault=%b busy=%b steps=%0d, required 1/0/1", z_fault, z_busy, z_steps);
    end
  endtask

  task automatic test_reset_mid_run();
    int k;
    logic [2:0] got;
    do_reset();
    for (int i = 0; i < 16; i++) load_one(3'($urandom_range(1, 7)));
    use_tbl = 1'b0; stub_ns = 8'h02; stub_ws = 3'd0; stub_dir = 1'b1;
    k = $urandom_range(1, 3);
    pulse_start();
    for (int c = 0; c < 2 * k + 1; c++) tick();
    n_cmp++;
    if (o_busy !== 1'b1 || o_steps !== 16'(k)) begin
      n_bad++; $display("FAIL midrun_pre: busy=%b steps=%0d, required 1/%0d", o_busy, o_steps, k);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_state !== 8'h00 || o_busy !== 1'b0 || o_steps !== 16'd0) begin
      n_bad++; $display("FAIL midrun_async: state=%h busy=%b steps=%0d, required 00/0/0", o_state, o_busy, o_steps);
    end
    tick();
    n_cmp++;
    if (o_state !== 8'h00 || o_busy !== 1'b0 || o_steps !== 16'd0 || o_dbg_head !== 4'd8) begin
      n_bad++; $display("FAIL midrun_edge: state=%h busy=%b steps=%0d head=%0d, required 00/0/0/8",
                        o_state, o_busy, o_steps, o_dbg_head);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      dump_one(got);
      n_cmp++;
      if (got !== 3'd0) begin
        n_bad++; $display("FAIL midrun_tape%0d: got %0d, required 0", i, got);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_sym = 3'd0; start = 1'b0; dump_en = 1'b0;
    z_start = 1'b0; z_dir = 1'b1; z_ws = 3'd0; z_ns = 8'h80;
    use_tbl = 1'b0; stub_dir = 1'b1; stub_ws = 3'd0; stub_ns = 8'h80;
    for (int s = 0; s < 3; s++)
      for (int y = 0; y < 8; y++) begin
        tbl_dir[s][y] = 1'b1; tbl_ws[s][y] = 3'd0; tbl_ns[s][y] = 8'h80;
      end
    test_reset();
    test_load_dump();
    test_single_step();
    test_back_to_back();
    test_random();
    test_bad_next_state();
    test_left_edge();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
